text_buffer: RTL and testbench

Character-code store for the 16x16 text box drawn on the VGA output. It holds 256 seven-bit character codes addressed by `char_xy`, and returns the code at the requested position one cycle later. The font ROM then turns that code into `char_pixels` for the character-box drawing stage. The write side accepts a byte stream over a valid/ready handshake, such as keyboard or UART data. It interprets printable and control bytes and maintains a cursor with wrap-around.

---
 rtl/text_buffer.sv | 137 +++++++++++++
 tb/tb_text_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer.sv
// Character-code store for the 16x16 VGA text box: a 256 x 7-bit RAM with a
// registered read port and a byte-stream write side that maintains a cursor.
module text_buffer #(
    parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] clr_addr_q, clr_addr_d;
    logic [7:0] cur_q, cur_d;
    logic       wr_ready_q, wr_ready_d;
    logic       busy_q, busy_d;
    logic [6:0] char_code_q;

    logic       accept_s;
    logic       we_s;
    logic [7:0] waddr_s;
    logic [6:0] wdata_s;

    logic [6:0] mem [256];

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign accept_s = wr_valid && wr_ready_q;

    // Next-state, cursor and RAM write-port selection.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cur_d      = cur_q;
        we_s       = 1'b0;
        waddr_s    = cur_q;
        wdata_s    = CLEAR_CHAR;
        case (state_q)
            ST_CLEAR: begin
                we_s       = 1'b1;
                waddr_s    = clr_addr_q;
                wdata_s    = CLEAR_CHAR;
                cur_d      = 8'h00;
                clr_addr_d = clr_addr_q + 8'd1;
                if (clr_addr_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (is_printable(wr_data)) begin
                    we_s    = 1'b1;
                    waddr_s = cur_q;
                    wdata_s = wr_data[6:0];
                    cur_d   = cur_q + 8'd1;
                end else begin
                    case (wr_data)
                        8'h0A: cur_d = {cur_q[7:4] + 4'd1, 4'd0};
                        8'h08: begin
                            // Backspace never wraps backwards past the origin.
                            if (cur_q != 8'h00) begin
                                cur_d   = cur_q - 8'd1;
                                we_s    = 1'b1;
                                waddr_s = cur_q - 8'd1;
                                wdata_s = CLEAR_CHAR;
                            end else begin
                                cur_d = cur_q;
                            end
                        end
                        8'h0C: begin
                            state_d    = ST_CLEAR;
                            clr_addr_d = 8'h00;
                            cur_d      = 8'h00;
                        end
                        default: cur_d = cur_q;
                    endcase
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = 8'h00;
                cur_d      = 8'h00;
            end
        endcase
        wr_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_CLEAR);
    end

    // Control state, cursor, handshake outputs and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= 8'h00;
            cur_q       <= 8'h00;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            char_code_q <= 7'h00;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            cur_q       <= cur_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            char_code_q <= mem[char_xy];
        end
    end

    // Character RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    assign char_code = char_code_q;
    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign cursor_x  = cur_q[3:0];
    assign cursor_y  = cur_q[7:4];

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: read expectations go through a scoreboard
// queue and are checked by a separate monitor when the read data is due.
module tb_text_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic       rd_tag = 1'b0;
    logic       rd_tag_q = 1'b0;
    logic [6:0] exp_q [$];
    logic [7:0] addr_q [$];

    text_buffer #(.CLEAR_CHAR(7'h20)) dut (
        .clk       (clk),
        .rst       (rst),
        .char_xy   (char_xy),
        .char_code (char_code),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_tag_q <= rd_tag;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read monitor: one cycle after a tagged address, compare against the queue head.
    always @(negedge clk) begin
        if (rd_tag_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_underflow: got %0h expected none", char_code);
            end else begin
                logic [6:0] e;
                logic [7:0] a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                chk($sformatf("read_%02h", a), {25'd0, char_code}, {25'd0, e});
            end
        end
    end

    task automatic rd(input logic [7:0] a, input logic [6:0] e);
        char_xy = a;
        rd_tag  = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(negedge clk);
        rd_tag = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("send_timeout", 32'(t), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic chk_cursor(input string name, input logic [3:0] x, input logic [3:0] y);
        chk({name, "_x"}, {28'd0, cursor_x}, {28'd0, x});
        chk({name, "_y"}, {28'd0, cursor_y}, {28'd0, y});
    endtask

    // Counts not-ready samples from the current negedge until wr_ready rises.
    task automatic wait_sweep(input string name);
        int n = 0;
        int bad = 0;
        while (!wr_ready && n < 2000) begin
            if (busy !== 1'b1 || cursor_x !== 4'd0 || cursor_y !== 4'd0) bad++;
            n++;
            @(negedge clk);
        end
        chk({name, "_len"}, 32'(n), 32'd256);
        chk({name, "_busy_cursor"}, 32'(bad), 32'd0);
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [7:0] wrap_code(input int i);
        return 8'h21 + 8'(i % 94);
    endfunction

    initial begin
        int c0;
        int w;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        char_xy  = 8'h00;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_code", {25'd0, char_code}, 32'd0);
        chk_cursor("rst_cursor", 4'd0, 4'd0);
        rst = 1'b0;
        wait_sweep("init_sweep");
        for (int a = 0; a < 256; a++) rd(8'(a), 7'h20);

        // Printable write, back-to-back
        c0 = cyc;
        send(8'h41);
        send(8'h42);
        chk("b2b_cycles", 32'(cyc - c0), 32'd2);
        chk_cursor("ab_cursor", 4'd2, 4'd0);
        rd(8'h00, 7'h41);
        rd(8'h01, 7'h42);

        // Back to origin via backspace, then wrap tests
        send(8'h08);
        send(8'h08);
        chk_cursor("bs_origin", 4'd0, 4'd0);
        rd(8'h01, 7'h20);
        for (int i = 0; i < 16; i++) send(8'h50 + 8'(i));
        chk_cursor("row_wrap", 4'd0, 4'd1);
        rd(8'h0F, 7'h5F);
        for (int i = 0; i < 240; i++) send(8'h61);
        chk_cursor("to_origin", 4'd0, 4'd0);
        for (int i = 0; i < 256; i++) send(wrap_code(i));
        chk_cursor("full_wrap", 4'd0, 4'd0);
        rd(8'hFF, 7'h64);
        rd(8'h00, 7'h21);
        rd(8'h10, 7'h31);

        // Control bytes
        send(8'h0A);
        send(8'h0A);
        send(8'h0A);
        chk_cursor("nl3", 4'd0, 4'd3);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        chk_cursor("pre_nl", 4'd5, 4'd3);
        send(8'h0A);
        chk_cursor("nl_53", 4'd0, 4'd4);
        send(8'h07);
        chk_cursor("bel", 4'd0, 4'd4);
        rd(8'h34, 7'h34);
        rd(8'h35, 7'h56);
        rd(8'h40, 7'h61);

        // Clear mid-text with a byte held during the sweep
        for (int i = 0; i < 10; i++) send(8'h41 + 8'(i));
        chk_cursor("pre_ff", 4'd10, 4'd4);
        send(8'h0C);
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        wait_sweep("ff_sweep");
        wr_valid = 1'b0;
        chk_cursor("ff_cursor", 4'd0, 4'd0);
        for (int a = 0; a < 256; a++) rd(8'(a), 7'h20);

        // Backspace across a row boundary and at the origin
        for (int i = 0; i < 16; i++) send(8'h41 + 8'(i));
        chk_cursor("row0", 4'd0, 4'd1);
        send(8'h08);
        chk_cursor("bs_row", 4'd15, 4'd0);
        rd(8'h0F, 7'h20);
        rd(8'h0E, 7'h4F);
        for (int i = 0; i < 15; i++) send(8'h08);
        chk_cursor("bs_all", 4'd0, 4'd0);
        send(8'h08);
        chk_cursor("bs_at0", 4'd0, 4'd0);
        rd(8'h00, 7'h20);
        rd(8'h10, 7'h20);

        // Reset at sweep address 100
        send(8'h0C);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, wr_ready}, 32'd0);
        chk("mid_rst_code", {25'd0, char_code}, 32'd0);
        rst = 1'b0;
        wait_sweep("rst_sweep");

        // Read/write collision at address 0x05
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        chk_cursor("pre_coll", 4'd5, 4'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        char_xy  = 8'h05;
        rd_tag   = 1'b1;
        exp_q.push_back(7'h20);
        addr_q.push_back(8'h05);
        @(negedge clk);
        wr_valid = 1'b0;
        exp_q.push_back(7'h5A);
        addr_q.push_back(8'h05);
        @(negedge clk);
        rd_tag = 1'b0;
        chk_cursor("post_coll", 4'd6, 4'd0);

        w = 0;
        while (exp_q.size() != 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
